// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte enables, 1/2-cycle read latency and post-reset clear.
// Optional per-byte even parity with error injection when RAM_SP_PARITY_EN is defined.
module ram_sp_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   be,
`ifdef RAM_SP_PARITY_EN
    input  logic                  inj_par,
    output logic                  parity_err,
`endif
    output logic                  ready,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  addr_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
            $error("ram_sp_param: READ_LAT must be 1 or 2");
        end
        if (DATA_W % 8 != 0) begin : g_bad_width
            $error("ram_sp_param: DATA_W must be a multiple of 8");
        end
        if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr
            $error("ram_sp_param: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    // Handshake: an access is taken at a rising edge when req && ready; req with ready low is dropped.
    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [31:0]       addr_ext;
    logic              in_range;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_data;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;

    assign idx      = addr[IDX_W-1:0];
    assign addr_ext = 32'(addr);
    assign in_range = addr_ext < 32'(DEPTH);
    assign acc      = req && ready;
    assign wr_acc   = acc && wr && in_range;
    assign rd_acc   = acc && !wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && cnt == IDX_W'(DEPTH - 1)) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        ready = (state == S_RUN);
    end

    // Storage has no reset; the INIT walk zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                mem[cnt] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rd_data = in_range ? mem[idx] : '0;

`ifdef RAM_SP_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];
    logic          rd_perr;
    logic          s_perr;

    // Zero data with zero parity bits is already consistent, so INIT clears both alike.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_INIT) begin
                pmem[cnt] <= '0;
            end else if (wr_acc) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        pmem[idx][i] <= (^din[8*i +: 8]) ^ inj_par;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_perr = 1'b0;
        if (in_range) begin
            for (int i = 0; i < NB; i++) begin
                rd_perr = rd_perr | (pmem[idx][i] ^ (^mem[idx][8*i +: 8]));
            end
        end
    end
`endif

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              p_valid;
            logic [DATA_W-1:0] p_data;
`ifdef RAM_SP_PARITY_EN
            logic              p_perr;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    p_valid <= 1'b0;
                    p_data  <= '0;
`ifdef RAM_SP_PARITY_EN
                    p_perr  <= 1'b0;
`endif
                end else begin
                    p_valid <= rd_acc;
                    if (rd_acc) begin
                        p_data <= rd_data;
`ifdef RAM_SP_PARITY_EN
                        p_perr <= rd_perr;
`endif
                    end
                end
            end
            assign s_valid = p_valid;
            assign s_data  = p_data;
`ifdef RAM_SP_PARITY_EN
            assign s_perr  = p_perr;
`endif
        end else begin : g_lat1
            assign s_valid = rd_acc;
            assign s_data  = rd_data;
`ifdef RAM_SP_PARITY_EN
            assign s_perr  = rd_perr;
`endif
        end
    endgenerate

    // dout only moves on a valid read so it holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            addr_err   <= 1'b0;
`ifdef RAM_SP_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            dout_valid <= s_valid;
            if (s_valid) begin
                dout <= s_data;
            end
            addr_err <= acc && !in_range;
`ifdef RAM_SP_PARITY_EN
            parity_err <= s_valid && s_perr;
`endif
        end
    end

endmodule
